// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//
// Free-running binary up-counter with clock enable. Advances by one on every
// enabled rising clk edge and wraps from MAX_COUNT back to 0, so the count is
// always in the range 0..MAX_COUNT.
//
// Optional feature: define COUNTER_WRAP_EN to add the registered `wrap`
// strobe. It is high for exactly the one cycle that follows an enabled edge
// at which the count rolled over from MAX_COUNT to 0. When the macro is not
// defined, the port and its register do not exist.
//
// Parameters
//   NUM_BITS   width of the count register (>= 1)
//   MAX_COUNT  terminal value, 0 < MAX_COUNT <= 2**NUM_BITS-1
//
// Ports
//   clk     in   1         rising-edge clock
//   rst     in   1         asynchronous reset, active low
//   enable  in   1         count enable, sampled on rising clk
//   count   out  NUM_BITS  current count, straight from a register
//   wrap    out  1         roll-over strobe (COUNTER_WRAP_EN only)
// ---------------------------------------------------------------------------
module counter #(
  parameter int                NUM_BITS  = 8,
  parameter longint unsigned   MAX_COUNT = (64'd1 << NUM_BITS) - 64'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [NUM_BITS-1:0] count
`ifdef COUNTER_WRAP_EN
  ,
  output logic                wrap
`endif
);

  localparam logic [NUM_BITS-1:0] MAX_VAL = MAX_COUNT[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] r_count;
  logic                w_at_max;

  // Terminal detect; shared by the roll-over and the wrap strobe.
  assign w_at_max = (r_count == MAX_VAL);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  // NOTE: the reset is in the sensitivity list, so the count clears the
  // moment rst falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_at_max) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + NUM_BITS'(1);
      end
    end
  end

  assign count = r_count;

`ifdef COUNTER_WRAP_EN
  logic r_wrap;

  // Registered strobe: set only by an enabled edge that rolls the count
  // over, cleared on every other edge (including disabled ones).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= enable && w_at_max;
    end
  end

  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_counter.sv
`timescale 1ns/100ps
module tb_counter;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] count8;
  logic [3:0] count9;
`ifdef COUNTER_WRAP_EN
  logic       wrap8;
  logic       wrap9;
`endif

  // Default configuration: 8 bits, natural 255 -> 0 roll-over.
  counter #(.NUM_BITS(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .count  (count8)
`ifdef COUNTER_WRAP_EN
    ,
    .wrap   (wrap8)
`endif
  );

  // Custom terminal value: 0..9 then 0.
  counter #(.NUM_BITS(4), .MAX_COUNT(9)) dut9 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .count  (count9)
`ifdef COUNTER_WRAP_EN
    ,
    .wrap   (wrap9)
`endif
  );

  always #1 clk = ~clk;

  typedef struct {
    string tag;
    int    c8;
    int    c9;
    logic  w8;
    logic  w9;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m8       = 0;
  int   m9       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction for the coming
  // edge, then sample away from the edge and compare against the popped entry.
  task automatic step(input string tag, input logic en);
    exp_t e;
    enable = en;
    e.tag = tag;
    e.w8  = 1'b0;
    e.w9  = 1'b0;
    if (!rst) begin
      m8 = 0;
      m9 = 0;
    end else if (en) begin
      e.w8 = (m8 == 255);
      e.w9 = (m9 == 9);
      m8   = (m8 + 1) % 256;
      m9   = (m9 + 1) % 10;
    end
    e.c8 = m8;
    e.c9 = m9;
    sb.push_back(e);
    @(posedge clk);
    #0.5;
    e = sb.pop_front();
    check({e.tag, ".count8"}, 32'(count8), 32'(e.c8));
    check({e.tag, ".count9"}, 32'(count9), 32'(e.c9));
`ifdef COUNTER_WRAP_EN
    check({e.tag, ".wrap8"}, 32'(wrap8), 32'(e.w8));
    check({e.tag, ".wrap9"}, 32'(wrap9), 32'(e.w9));
`endif
  endtask

  initial begin
    // Reset asserted, enable low: 10 ns of reset.
    #0.1 rst = 1'b0;
    #0.1;
    check("reset_async.count8", 32'(count8), 32'd0);
    check("reset_async.count9", 32'(count9), 32'd0);
    #0.3;
    for (int i = 0; i < 5; i++) step("reset_hold", 1'b0);

    // Release mid-cycle, stay paused for 10 ns.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step("post_reset_pause", 1'b0);

    // Enable window: 25 edges -> 25.
    for (int i = 0; i < 25; i++) step("enable_window", 1'b1);
    check("after_25.count8", 32'(count8), 32'd25);

    // Pause 5 edges: holds 25.
    for (int i = 0; i < 5; i++) step("pause", 1'b0);

    // Resume 25 more edges -> 50.
    for (int i = 0; i < 25; i++) step("resume", 1'b1);
    check("after_50.count8", 32'(count8), 32'd50);

    // Async reset between edges with enable high.
    enable = 1'b1;
    rst    = 1'b0;
    #0.1;
    check("midcycle_reset.count8", 32'(count8), 32'd0);
    check("midcycle_reset.count9", 32'(count9), 32'd0);
    m8 = 0;
    m9 = 0;
    #0.4;
    for (int i = 0; i < 25; i++) step("reset_while_enabled", 1'b1);

    // Release; first enabled edge gives 1.
    rst = 1'b1;
    step("first_after_release", 1'b1);
    check("first_after_release.direct", 32'(count8), 32'd1);

    // Run up to 253, then across the 255 -> 0 roll-over.
    while (m8 != 253) step("run_up", 1'b1);
    for (int i = 0; i < 5; i++) step("wrap_255", 1'b1);

    // Toggling enable: one increment per enabled edge, no wrap on disabled edges.
    for (int i = 0; i < 40; i++) step("toggle", (i % 2) == 0);

    // Land dut9 on its terminal, roll over, then hold at 0 with enable low.
    while (m9 != 9) step("to_nine", 1'b1);
    step("wrap_nine", 1'b1);
    for (int i = 0; i < 3; i++) step("hold_zero", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
